board_ctl: RTL and testbench



---
 rtl/board_pkg.sv | 33 +++
 rtl/board_win_check.sv | 24 ++
 rtl/board_ctl.sv | 194 +++++++++++++++++++
 tb/tb_board_ctl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types and constants for the tic-tac-toe board controller:
// FSM states, player colours, winner codes and the table of winning lines.
package board_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DECODE,
        S_UPDATE,
        S_CHECK,
        S_OVER
    } state_t;

    localparam logic [11:0] COLOR_A = 12'h000;
    localparam logic [11:0] COLOR_B = 12'hFFF;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;

    // Square indices 0..8, row-major from the top-left corner.
    localparam int N_LINES = 8;
    localparam int WIN_LINES [N_LINES][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic logic [11:0] player_color(input logic player);
        return player ? COLOR_B : COLOR_A;
    endfunction

endpackage

// File: rtl/board_win_check.sv
// Combinational line detector: flags a win when any row, column or diagonal
// is fully occupied by squares belonging to the player given by the owner mask.
module board_win_check
    import board_pkg::*;
(
    input  logic [8:0] occupied,
    input  logic [8:0] owner,
    output logic       win
);

    logic [8:0] mine;

    assign mine = occupied & owner;

    always_comb begin
        win = 1'b0;
        for (int l = 0; l < N_LINES; l++) begin
            if (mine[WIN_LINES[l][0]] && mine[WIN_LINES[l][1]] && mine[WIN_LINES[l][2]]) begin
                win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_ctl.sv
// Game-state controller: turns mouse clicks into square moves, alternates turns,
// detects win/draw. Optional press debounce under macro BOARD_CTL_DEBOUNCE_EN.
module board_ctl
    import board_pkg::*;
#(
    parameter int X1   = 342,
    parameter int X2   = 685,
    parameter int Y1   = 259,
    parameter int Y2   = 509,
    parameter int HMAX = 1024,
    parameter int VMAX = 768
`ifdef BOARD_CTL_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic [11:0]   mouse_xpos,
    input  logic [11:0]   mouse_ypos,
    input  logic          mouse_left,
    input  logic          start_en,
    input  logic          choice_en,
    input  logic          first_player,
    output logic [8:0]    square,
    output logic [107:0]  square_color,
    output logic          turn,
    output logic          game_over,
    output logic [1:0]    winner
);

    localparam logic [11:0] X1_L   = X1[11:0];
    localparam logic [11:0] X2_L   = X2[11:0];
    localparam logic [11:0] HMAX_L = HMAX[11:0];
    localparam logic [11:0] Y1_L   = Y1[11:0];
    localparam logic [11:0] Y2_L   = Y2[11:0];
    localparam logic [11:0] VMAX_L = VMAX[11:0];

    state_t      state;
    state_t      state_n;
    logic        play;
    logic        click;
    logic [11:0] x_q;
    logic [11:0] y_q;
    logic [3:0]  idx_q;
    logic [8:0]  owner_b;
    logic [8:0]  owner_cur;
    logic [1:0]  col;
    logic [1:0]  row;
    logic        coord_ok;
    logic [3:0]  idx_c;
    logic        win;
    logic        full;

    assign play = start_en && !choice_en;

`ifdef BOARD_CTL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] high_cnt;

    // Saturating count of consecutive high samples; the press fires once, on reaching the limit.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            high_cnt <= '0;
        end else if (!mouse_left) begin
            high_cnt <= '0;
        end else if (high_cnt != DB_MAX) begin
            high_cnt <= high_cnt + 1'b1;
        end
    end

    assign click = mouse_left && (high_cnt == DB_LAST);
`else
    logic left_prev;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            left_prev <= 1'b0;
        end else begin
            left_prev <= mouse_left;
        end
    end

    assign click = mouse_left && !left_prev;
`endif

    // Map the captured pointer position to a square; off-screen positions are rejected.
    always_comb begin
        col      = 2'd0;
        row      = 2'd0;
        coord_ok = 1'b1;
        if (x_q < X1_L)        col = 2'd0;
        else if (x_q < X2_L)   col = 2'd1;
        else if (x_q < HMAX_L) col = 2'd2;
        else                   coord_ok = 1'b0;
        if (y_q < Y1_L)        row = 2'd0;
        else if (y_q < Y2_L)   row = 2'd1;
        else if (y_q < VMAX_L) row = 2'd2;
        else                   coord_ok = 1'b0;
        idx_c = {2'b00, row} * 4'd3 + {2'b00, col};
    end

    assign owner_cur = turn ? owner_b : ~owner_b;
    assign full      = &square;

    board_win_check u_win_check (
        .occupied (square),
        .owner    (owner_cur),
        .win      (win)
    );

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        if (!play) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   state_n = S_WAIT;
                S_WAIT:   if (click) state_n = S_DECODE;
                S_DECODE: state_n = coord_ok ? S_UPDATE : S_WAIT;
                S_UPDATE: state_n = square[idx_q] ? S_WAIT : S_CHECK;
                S_CHECK:  state_n = (win || full) ? S_OVER : S_WAIT;
                S_OVER:   state_n = S_OVER;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            square       <= '0;
            square_color <= '0;
            owner_b      <= '0;
            turn         <= 1'b0;
            game_over    <= 1'b0;
            winner       <= WIN_NONE;
            x_q          <= '0;
            y_q          <= '0;
            idx_q        <= '0;
        end else if (!play || state == S_IDLE) begin
            square       <= '0;
            square_color <= '0;
            owner_b      <= '0;
            game_over    <= 1'b0;
            winner       <= WIN_NONE;
            if (play) begin
                turn <= first_player;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    if (click) begin
                        x_q <= mouse_xpos;
                        y_q <= mouse_ypos;
                    end
                end
                S_DECODE: idx_q <= idx_c;
                S_UPDATE: begin
                    if (!square[idx_q]) begin
                        square[idx_q]              <= 1'b1;
                        owner_b[idx_q]             <= turn;
                        square_color[12*idx_q +: 12] <= player_color(turn);
                    end
                end
                S_CHECK: begin
                    if (win) begin
                        game_over <= 1'b1;
                        winner    <= turn ? WIN_B : WIN_A;
                    end else if (full) begin
                        game_over <= 1'b1;
                        winner    <= WIN_NONE;
                    end else begin
                        turn <= ~turn;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_ctl.sv
// Self-checking bench for board_ctl: a reference game model pushes the expected
// board after every click; the DUT outputs are popped and compared at fixed latency.
module tb_board_ctl;

`ifdef BOARD_CTL_DEBOUNCE_EN
    localparam int HOLD = 16;
`else
    localparam int HOLD = 1;
`endif

    logic          pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic [11:0]   mouse_xpos = '0;
    logic [11:0]   mouse_ypos = '0;
    logic          mouse_left = 1'b0;
    logic          start_en = 1'b0;
    logic          choice_en = 1'b0;
    logic          first_player = 1'b0;
    logic [8:0]    square;
    logic [107:0]  square_color;
    logic          turn;
    logic          game_over;
    logic [1:0]    winner;

    board_ctl dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .mouse_xpos   (mouse_xpos),
        .mouse_ypos   (mouse_ypos),
        .mouse_left   (mouse_left),
        .start_en     (start_en),
        .choice_en    (choice_en),
        .first_player (first_player),
        .square       (square),
        .square_color (square_color),
        .turn         (turn),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [8:0]   sq;
        logic [107:0] col;
        logic         prev_turn;
        logic         turn;
        logic         go;
        logic [1:0]   win;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference game model
    logic [8:0] m_sq;
    logic [8:0] m_b;
    logic       m_turn;
    logic       m_go;
    logic [1:0] m_win;
    int         lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                 '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic int coord_idx(input int x, input int y);
        int c;
        int r;
        if (x < 342) c = 0; else if (x < 685) c = 1; else if (x < 1024) c = 2; else return -1;
        if (y < 259) r = 0; else if (y < 509) r = 1; else if (y < 768) r = 2; else return -1;
        return r * 3 + c;
    endfunction

    function automatic int cx(input int k);
        return (k % 3 == 0) ? 100 : (k % 3 == 1) ? 500 : 900;
    endfunction

    function automatic int cy(input int k);
        return (k / 3 == 0) ? 100 : (k / 3 == 1) ? 400 : 700;
    endfunction

    function automatic logic m_line(input logic [8:0] mine);
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < 8; l++)
            if (mine[lines[l][0]] && mine[lines[l][1]] && mine[lines[l][2]]) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [107:0] exp_color(input logic [8:0] sq, input logic [8:0] b);
        logic [107:0] c;
        c = '0;
        for (int k = 0; k < 9; k++)
            if (sq[k] && b[k]) c[12*k +: 12] = 12'hFFF;
        return c;
    endfunction

    task automatic model_reset(input logic fp);
        m_sq = '0; m_b = '0; m_turn = fp; m_go = 1'b0; m_win = 2'b00;
    endtask

    task automatic model_click(input int x, input int y);
        int idx;
        logic [8:0] mine;
        idx = coord_idx(x, y);
        if (m_go || idx < 0) return;
        if (m_sq[idx]) return;
        m_sq[idx] = 1'b1;
        m_b[idx]  = m_turn;
        mine = m_sq & (m_turn ? m_b : ~m_b);
        if (m_line(mine)) begin
            m_go = 1'b1; m_win = m_turn ? 2'b10 : 2'b01;
        end else if (&m_sq) begin
            m_go = 1'b1; m_win = 2'b00;
        end else begin
            m_turn = ~m_turn;
        end
    endtask

    // Drives one press from a negedge, scores the board at N+3 and turn/result at N+4.
    task automatic play_click(input int x, input int y, input string tag);
        exp_t e;
        e.prev_turn = m_turn;
        model_click(x, y);
        e.sq = m_sq; e.col = exp_color(m_sq, m_b); e.turn = m_turn;
        e.go = m_go; e.win = m_win; e.tag = tag;
        sb.push_back(e);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        mouse_left = 1'b1;
        repeat (HOLD) @(posedge pclk);
        @(negedge pclk);
        mouse_left = 1'b0;
        repeat (2) @(negedge pclk);
        e = sb.pop_front();
        n_checks++;
        if (square !== e.sq) begin
            n_fail++; $display("FAIL %s square: got %b expected %b", e.tag, square, e.sq);
        end
        n_checks++;
        if (square_color !== e.col) begin
            n_fail++; $display("FAIL %s square_color: got %h expected %h", e.tag, square_color, e.col);
        end
        n_checks++;
        if (turn !== e.prev_turn) begin
            n_fail++; $display("FAIL %s turn_early: got %b expected %b", e.tag, turn, e.prev_turn);
        end
        @(negedge pclk);
        n_checks++;
        if (turn !== e.turn) begin
            n_fail++; $display("FAIL %s turn: got %b expected %b", e.tag, turn, e.turn);
        end
        n_checks++;
        if (game_over !== e.go || winner !== e.win) begin
            n_fail++;
            $display("FAIL %s result: got go=%b winner=%b expected go=%b winner=%b",
                     e.tag, game_over, winner, e.go, e.win);
        end
    endtask

    task automatic new_game(input logic fp);
        start_en = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (square !== 9'd0 || square_color !== '0 || game_over !== 1'b0 || winner !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_clear: got sq=%b go=%b winner=%b expected all zero", square, game_over, winner);
        end
        first_player = fp;
        start_en = 1'b1;
        repeat (2) @(negedge pclk);
        model_reset(fp);
        n_checks++;
        if (turn !== fp) begin
            n_fail++; $display("FAIL first_player: got %b expected %b", turn, fp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge pclk);
        n_checks++;
        if (square !== 9'd0 || square_color !== '0 || turn !== 1'b0 ||
            game_over !== 1'b0 || winner !== 2'b00) begin
            n_fail++;
            $display("FAIL reset: got sq=%b turn=%b go=%b winner=%b expected zeros", square, turn, game_over, winner);
        end
        rst_n = 1'b1;
        first_player = 1'b0;
        start_en = 1'b1;
        repeat (2) @(negedge pclk);
        model_reset(1'b0);
        n_checks++;
        if (turn !== 1'b0 || square !== 9'd0) begin
            n_fail++; $display("FAIL game_entry: got turn=%b sq=%b expected 0/0", turn, square);
        end
    endtask

    task automatic test_moves();
        play_click(100, 100, "first_move");
        play_click(100, 100, "occupied");
        play_click(685, 259, "boundary_x2_y1");
        play_click(1024, 300, "x_hmax_invalid");
        play_click(300, 768, "y_vmax_invalid");
        play_click(684, 258, "boundary_below");
        play_click(1023, 767, "last_pixel");
        play_click(341, 508, "col0_row1_edge");
    endtask

    task automatic test_win();
        new_game(1'b0);
        play_click(cx(0), cy(0), "win_a1");
        play_click(cx(3), cy(3), "win_b4");
        play_click(cx(1), cy(1), "win_a2");
        play_click(cx(4), cy(4), "win_b5");
        play_click(cx(2), cy(2), "win_a3");
        play_click(cx(8), cy(8), "over_ignored");
    endtask

    task automatic test_draw();
        int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        new_game(1'b0);
        for (int i = 0; i < 9; i++) play_click(cx(seq[i]), cy(seq[i]), "draw_move");
        start_en = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (square !== 9'd0 || game_over !== 1'b0 || winner !== 2'b00) begin
            n_fail++;
            $display("FAIL draw_exit: got sq=%b go=%b winner=%b expected zeros", square, game_over, winner);
        end
        start_en = 1'b1;
        repeat (2) @(negedge pclk);
        model_reset(first_player);
    endtask

    task automatic test_choice_player_b();
        new_game(1'b1);
        play_click(cx(4), cy(4), "b_first_move");
        choice_en = 1'b1;
        @(negedge pclk);
        n_checks++;
        if (square !== 9'd0 || square_color !== '0) begin
            n_fail++; $display("FAIL choice_clear: got sq=%b expected 0", square);
        end
        choice_en = 1'b0;
        repeat (2) @(negedge pclk);
        model_reset(1'b1);
        n_checks++;
        if (turn !== 1'b1) begin
            n_fail++; $display("FAIL choice_reentry: got turn=%b expected 1", turn);
        end
    endtask

`ifdef BOARD_CTL_DEBOUNCE_EN
    task automatic test_debounce();
        exp_t e;
        mouse_xpos = 12'(cx(8));
        mouse_ypos = 12'(cy(8));
        mouse_left = 1'b1;
        repeat (10) @(negedge pclk);
        mouse_left = 1'b0;
        repeat (20) @(negedge pclk);
        n_checks++;
        if (square !== m_sq || turn !== m_turn) begin
            n_fail++; $display("FAIL glitch: got sq=%b turn=%b expected sq=%b turn=%b", square, turn, m_sq, m_turn);
        end
        e.prev_turn = m_turn;
        model_click(cx(8), cy(8));
        e.sq = m_sq; e.turn = m_turn; e.col = '0; e.go = m_go; e.win = m_win; e.tag = "long_press";
        sb.push_back(e);
        mouse_left = 1'b1;
        repeat (40) @(negedge pclk);
        mouse_left = 1'b0;
        repeat (4) @(negedge pclk);
        e = sb.pop_front();
        n_checks++;
        if (square !== e.sq || turn !== e.turn) begin
            n_fail++; $display("FAIL %s: got sq=%b turn=%b expected sq=%b turn=%b", e.tag, square, turn, e.sq, e.turn);
        end
    endtask
`else
    // A second rising edge while the first click is in flight must be dropped.
    task automatic test_back_to_back();
        exp_t e;
        e.prev_turn = m_turn;
        model_click(cx(0), cy(0));
        e.sq = m_sq; e.turn = m_turn; e.col = exp_color(m_sq, m_b); e.go = m_go; e.win = m_win; e.tag = "b2b";
        sb.push_back(e);
        mouse_xpos = 12'(cx(0));
        mouse_ypos = 12'(cy(0));
        mouse_left = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        mouse_left = 1'b0;
        mouse_xpos = 12'(cx(2));
        mouse_ypos = 12'(cy(2));
        @(negedge pclk);
        mouse_left = 1'b1;
        @(negedge pclk);
        mouse_left = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (square !== e.sq) begin
            n_fail++; $display("FAIL %s square: got %b expected %b", e.tag, square, e.sq);
        end
        repeat (7) @(negedge pclk);
        n_checks++;
        if (square !== e.sq || turn !== e.turn || square_color !== e.col) begin
            n_fail++; $display("FAIL %s dropped: got sq=%b turn=%b expected sq=%b turn=%b", e.tag, square, turn, e.sq, e.turn);
        end
    endtask
`endif

    task automatic test_mid_reset();
        mouse_xpos = 12'(cx(6));
        mouse_ypos = 12'(cy(6));
        mouse_left = 1'b1;
        repeat (HOLD) @(posedge pclk);
        @(negedge pclk);
        mouse_left = 1'b0;
        rst_n = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (square !== 9'd0 || square_color !== '0 || turn !== 1'b0 ||
            game_over !== 1'b0 || winner !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset: got sq=%b turn=%b go=%b expected zeros", square, turn, game_over);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge pclk);
        model_reset(first_player);
        n_checks++;
        if (square !== 9'd0 || turn !== m_turn) begin
            n_fail++; $display("FAIL post_reset: got sq=%b turn=%b expected 0/%b", square, turn, m_turn);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge pclk);
        test_reset();
        test_moves();
        test_win();
        test_draw();
        test_choice_player_b();
`ifdef BOARD_CTL_DEBOUNCE_EN
        test_debounce();
`else
        test_back_to_back();
`endif
        test_mid_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
